// File: rtl/rfphoenix_valu_arbiter_pkg.sv
// Shared types and defaults for the vector-ALU arbiter: precision and vector
// value types, FSM state encoding and the in-flight pipeline entry.
package rfPhoenixPkg;

  localparam int VALU_NREQ   = 4;
  localparam int VALU_LAT    = 3;
  localparam int VALU_LANES  = 4;
  localparam int VALU_LANE_W = 32;
  // Wide enough for any practical requester count; upper bits stay zero.
  localparam int VALU_IDX_W  = 8;

  typedef logic [1:0] prec_t;
  typedef logic [VALU_LANES-1:0][VALU_LANE_W-1:0] vector_value_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } valu_state_t;

  typedef struct packed {
    logic                  v;
    logic [VALU_IDX_W-1:0] idx;
  } valu_inflight_t;

endpackage

// File: rtl/rfphoenix_valu_arbiter_rr.sv
// Round-robin search: the first eligible requester after ptr (wrapping) wins.
module rfphoenix_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [SELW-1:0] ptr,
  output logic [NREQ-1:0] grant
);

  logic [SELW-1:0] cand_idx;

  // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin
    grant    = '0;
    cand_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_idx = SELW'((int'(ptr) + k) % NREQ);
      if (eligible[cand_idx]) begin
        grant           = '0;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rfphoenix_valu_arbiter.sv
// Shares one fixed-latency vector ALU among NREQ requesters with per-requester
// result slots and a drain/halt handshake. Define RFPHOENIX_VALU_PRIO_EN to give
// requester 0 absolute priority over the round-robin order.
module rfphoenix_valu_arbiter
  import rfPhoenixPkg::*;
#(
  parameter int NREQ = VALU_NREQ,
  parameter int LAT  = VALU_LAT,
  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic          [NREQ-1:0]   req_valid,
  input  prec_t         [NREQ-1:0]   req_prc,
  output logic          [NREQ-1:0]   req_ready,
  output logic                       alu_issue,
  output logic          [SELW-1:0]   alu_sel,
  output prec_t                      alu_prc,
  input  vector_value_t              alu_o,
  output logic          [NREQ-1:0]   rsp_valid,
  input  logic          [NREQ-1:0]   rsp_ready,
  output vector_value_t [NREQ-1:0]   rsp_data,
  input  logic                       drain_req,
  output logic                       drain_ack,
  output logic                       busy,
  output valu_state_t                dbg_state
);

  // Handshake: a request transfers in the cycle req_valid[i] && req_ready[i];
  // a result slot empties in the cycle rsp_valid[i] && rsp_ready[i].

  valu_state_t                state_q, state_d;
  logic          [SELW-1:0]   ptr_q, ptr_d;
  valu_inflight_t [LAT-1:0]   infl_q, infl_d;
  logic          [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  vector_value_t [NREQ-1:0]   rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] rr_grant;
  logic [NREQ-1:0] grant;
  logic            ptr_upd;

  always_comb begin
    pending = '0;
    busy    = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      if (infl_q[s].v) busy = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (infl_q[s].v && (infl_q[s].idx == VALU_IDX_W'(i))) pending[i] = 1'b1;
      end
    end
  end

  // drain_req blocks grants in the very cycle it is first seen in RUN.
  always_comb begin
    eligible = '0;
    if ((state_q == RUN) && !drain_req) eligible = req_valid & ~pending & ~rsp_valid_q;
  end

  rfphoenix_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (rr_grant)
  );

  always_comb begin
    grant   = rr_grant;
    ptr_upd = 1'b1;
`ifdef RFPHOENIX_VALU_PRIO_EN
    if (eligible[0]) begin
      grant   = NREQ'(1);
      ptr_upd = 1'b0;
    end
`endif
  end

  always_comb begin
    req_ready = grant;
    alu_issue = |grant;
    alu_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) alu_sel = SELW'(i);
    end
    alu_prc = alu_issue ? req_prc[alu_sel] : '0;
    ptr_d   = (alu_issue && ptr_upd) ? alu_sel : ptr_q;
  end

  always_comb begin
    infl_d        = '0;
    infl_d[0].v   = alu_issue;
    infl_d[0].idx = VALU_IDX_W'(alu_sel);
    for (int s = 1; s < LAT; s++) infl_d[s] = infl_q[s-1];
  end

  // One outstanding op per requester means capture and pop never share a slot.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NREQ; i++) begin
      if (infl_q[LAT-1].v && (infl_q[LAT-1].idx == VALU_IDX_W'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = alu_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SELW'(NREQ - 1);
      infl_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      infl_q      <= infl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Dropping drain_req wins over reaching empty, so DRAIN can return to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (!drain_req) state_d = RUN;
               else if (!busy) state_d = HALT;
      HALT:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    drain_ack = (state_q == HALT);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_rfphoenix_valu_arbiter.sv
// Directed bench for rfphoenix_valu_arbiter (NREQ=4, LAT=3) with an ALU model
// and a result scoreboard.
module tb_rfphoenix_valu_arbiter;
  import rfPhoenixPkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int SELW = 2;
  localparam int W    = SELW + 128;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic          [NREQ-1:0]  req_valid;
  prec_t         [NREQ-1:0]  req_prc;
  logic          [NREQ-1:0]  req_ready;
  logic                      alu_issue;
  logic          [SELW-1:0]  alu_sel;
  prec_t                     alu_prc;
  vector_value_t             alu_o;
  logic          [NREQ-1:0]  rsp_valid;
  logic          [NREQ-1:0]  rsp_ready;
  vector_value_t [NREQ-1:0]  rsp_data;
  logic                      drain_req;
  logic                      drain_ack;
  logic                      busy;
  valu_state_t               dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  exp_q[$];
  logic          pipe_v [0:LAT];
  vector_value_t pipe_d [0:LAT];
  logic [NREQ-1:0] prev_rv;
  bit            pattern_mode;

  rfphoenix_valu_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_prc   (req_prc),
    .req_ready (req_ready),
    .alu_issue (alu_issue),
    .alu_sel   (alu_sel),
    .alu_prc   (alu_prc),
    .alu_o     (alu_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .drain_req (drain_req),
    .drain_ack (drain_ack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic vector_value_t lane_pattern();
    vector_value_t v;
    for (int l = 0; l < VALU_LANES; l++) v[l] = 32'hA5A5_0000 + 32'(l);
    return v;
  endfunction

  function automatic vector_value_t rand_vec();
    vector_value_t v;
    for (int l = 0; l < VALU_LANES; l++) v[l] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [NREQ-1:0] exp);
    logic [SELW-1:0] s;
    s = '0;
    for (int i = 0; i < NREQ; i++) if (exp[i]) s = SELW'(i);
    chk({tag, "_ready"}, W'(req_ready), W'(exp));
    chk({tag, "_issue"}, W'(alu_issue), W'(|exp));
    chk({tag, "_sel"},   W'(alu_sel),   (|exp) ? W'(s) : '0);
    chk({tag, "_prc"},   W'(alu_prc),   (|exp) ? W'(req_prc[s]) : '0);
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // ALU model and scoreboard: results return LAT cycles after issue; every
  // newly filled slot must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= LAT; s++) begin
        pipe_v[s] = 1'b0;
        pipe_d[s] = '0;
      end
      exp_q.delete();
      prev_rv = '0;
      alu_o   = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && !prev_rv[i]) begin
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL capture_unexpected slot=%0d observed=1 expected=0", i);
          end
          if (exp_q.size() > 0) chk($sformatf("capture_slot%0d", i), {SELW'(i), rsp_data[i]}, exp_q.pop_front());
        end
      end
      prev_rv = rsp_valid;
      for (int s = LAT; s >= 1; s--) begin
        pipe_v[s] = pipe_v[s-1];
        pipe_d[s] = pipe_d[s-1];
      end
      pipe_v[0] = alu_issue;
      pipe_d[0] = pattern_mode ? lane_pattern() : rand_vec();
      if (alu_issue) exp_q.push_back({alu_sel, pipe_d[0]});
      alu_o = pipe_v[LAT] ? pipe_d[LAT] : rand_vec();
    end
  end

  logic [NREQ-1:0] one;
  logic [NREQ-1:0] v5_exp [0:11];

  initial begin
    one          = 4'b0001;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_prc      = {2'd0, 2'd1, 2'd2, 2'd3};
    rsp_ready    = '0;
    drain_req    = 1'b0;
    pattern_mode = 1'b0;
`ifdef RFPHOENIX_VALU_PRIO_EN
    v5_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
               4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
`else
    v5_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
               4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_busy",      W'(busy),      '0);
    chk("rst_drain_ack", W'(drain_ack), '0);
    chk("rst_state",     W'(dbg_state), W'(RUN));
    for (int i = 0; i < NREQ; i++) chk($sformatf("rst_rsp_data%0d", i), W'(rsp_data[i]), '0);
    rst_n = 1'b1;

    // V1: all requesters valid from reset, no pops
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      neg();
      chk_grant($sformatf("v1_c%0d", c), (c < 4) ? (one << c) : 4'b0000);
      chk($sformatf("v1_rsp_valid_c%0d", c), W'(rsp_valid), (c < 4) ? '0 : W'(4'b1111 >> (7 - c)));
      chk($sformatf("v1_busy_c%0d", c), W'(busy), W'((c >= 1) && (c <= 6)));
      nxt();
    end
    rsp_ready = 4'b0001;
    neg();
    chk_grant("v1_pop_cycle", 4'b0000);
    chk("v1_pop_rsp_valid", W'(rsp_valid), W'(4'b1111));
    nxt();
    rsp_ready = '0;
    neg();
    chk_grant("v1_regrant", 4'b0001);
    chk("v1_after_pop_rsp_valid", W'(rsp_valid), W'(4'b1110));
    nxt();
    req_valid = '0;
    rsp_ready = 4'hF;
    repeat (8) nxt();
    rsp_ready = '0;

    // V2: requester 2 alone, slot held full
    req_valid = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      neg();
      chk_grant($sformatf("v2_c%0d", c), (c == 0) ? 4'b0100 : 4'b0000);
      if (c >= 4) chk($sformatf("v2_rsp_valid_c%0d", c), W'(rsp_valid), W'(4'b0100));
      nxt();
    end
    rsp_ready = 4'b0100;
    neg();
    chk_grant("v2_pop_cycle", 4'b0000);
    nxt();
    rsp_ready = '0;
    neg();
    chk_grant("v2_regrant", 4'b0100);
    chk("v2_slot_empty", W'(rsp_valid), '0);
    nxt();
    req_valid = '0;
    rsp_ready = 4'hF;
    repeat (8) nxt();

    // V3: drain after three grants, then resume
    req_valid = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) drain_req = 1'b1;
      if (c == 8) drain_req = 1'b0;
      neg();
      chk_grant($sformatf("v3_c%0d", c), (c < 3) ? (one << c) : ((c == 9) ? 4'b0001 : 4'b0000));
      chk($sformatf("v3_drain_ack_c%0d", c), W'(drain_ack), W'((c == 7) || (c == 8)));
      if (c == 5) chk("v3_busy_c5", W'(busy), W'(1'b1));
      if (c == 6) begin
        chk("v3_busy_c6", W'(busy), '0);
        chk("v3_state_c6", W'(dbg_state), W'(DRAIN));
      end
      if (c == 7) chk("v3_state_c7", W'(dbg_state), W'(HALT));
      if (c == 9) chk("v3_state_c9", W'(dbg_state), W'(RUN));
      nxt();
    end
    req_valid = '0;
    repeat (8) nxt();
    rsp_ready = '0;

    // V4: reset with two ops in flight
    req_valid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      neg();
      chk($sformatf("v4_issue_c%0d", c), W'(alu_issue), W'(1'b1));
      nxt();
    end
    neg();
    chk("v4_busy_before_reset", W'(busy), W'(1'b1));
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk("v4_busy_async",      W'(busy),      '0);
    chk("v4_rsp_valid_async", W'(rsp_valid), '0);
    chk("v4_drain_ack_async", W'(drain_ack), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      neg();
      chk($sformatf("v4_no_capture_c%0d", c), W'({busy, rsp_valid}), '0);
      nxt();
    end

    // V5: requesters 0 and 1 with immediate pops
    rsp_ready = 4'hF;
    req_valid = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) req_valid = 4'b0011;
      neg();
      chk_grant($sformatf("v5_c%0d", c), v5_exp[c]);
      nxt();
    end
    req_valid = '0;
    repeat (8) nxt();
    rsp_ready = '0;

    // V6: lane pattern returned to requester 3
    pattern_mode = 1'b1;
    req_valid    = 4'b1000;
    neg();
    chk_grant("v6_grant", 4'b1000);
    nxt();
    req_valid = '0;
    for (int c = 1; c < 5; c++) begin
      neg();
      chk($sformatf("v6_rsp_valid3_c%0d", c), W'(rsp_valid[3]), W'(c == 4));
      nxt();
    end
    chk("v6_rsp_data3", W'(rsp_data[3]), W'(lane_pattern()));
    rsp_ready = 4'b1000;
    nxt();
    rsp_ready    = '0;
    pattern_mode = 1'b0;
    neg();
    chk("v6_popped",      W'(rsp_valid),   '0);
    chk("v6_data_held",   W'(rsp_data[3]), W'(lane_pattern()));
    nxt();

    repeat (2) nxt();
    chk("scoreboard_drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
